missile_ctl: RTL and testbench



---
 rtl/missile_ctl_if.sv | 23 ++
 rtl/missile_ctl.sv | 106 ++++++++++
 tb/tb_missile_ctl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/missile_ctl_if.sv
// Missile controller port bundle: ship/fire/frame inputs and missile position outputs.
// master drives the controller inputs; slave is the controller side.
interface missile_ctl_if;
   logic        fire;
   logic [10:0] ship_xpos;
   logic [10:0] ship_ypos;
   logic        vblnk_in;
   logic        hit;
   logic [10:0] xpos;
   logic [10:0] ypos;
   logic        on;
   logic        ready;

   modport master (
      output fire, ship_xpos, ship_ypos, vblnk_in, hit,
      input  xpos, ypos, on, ready
   );

   modport slave (
      input  fire, ship_xpos, ship_ypos, vblnk_in, hit,
      output xpos, ypos, on, ready
   );
endinterface

// File: rtl/missile_ctl.sv
// Player missile motion controller: launch, per-frame climb, retire, cooldown.
// Optional AUTOFIRE_EN: launch on fire level instead of fire rising edge.
module missile_ctl #(
   parameter int STEP            = 8,
   parameter int MISSILE_H       = 20,
   parameter int COOLDOWN_FRAMES = 10
) (
   input  logic         pclk,
   input  logic         rst,
   missile_ctl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FLY  = 2'd1;
   localparam logic [1:0] S_COOL = 2'd2;

   localparam logic [10:0] STEP_W = 11'(STEP);
   localparam logic [10:0] H_W    = 11'(MISSILE_H);
   localparam logic [7:0]  COOL_W = 8'(COOLDOWN_FRAMES);

   logic [1:0]  state_q, state_d;
   logic [10:0] xpos_q, xpos_d;
   logic [10:0] ypos_q, ypos_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        on_q, ready_q;
   logic        fire_q, vblnk_q;
   logic        fire_edge, tick, launch, retire;

   assign fire_edge = bus.fire & ~fire_q;
   assign tick      = bus.vblnk_in & ~vblnk_q;

`ifdef AUTOFIRE_EN
   assign launch = bus.fire | fire_edge;
`else
   assign launch = fire_edge;
`endif

   always_comb begin
      state_d = state_q;
      xpos_d  = xpos_q;
      ypos_d  = ypos_q;
      cnt_d   = cnt_q;
      retire  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (launch && (bus.ship_ypos >= H_W)) begin
               xpos_d  = bus.ship_xpos;
               ypos_d  = bus.ship_ypos - H_W;
               state_d = S_FLY;
            end
         end
         S_FLY: begin
            // hit wins over a simultaneous frame tick
            if (bus.hit) begin
               retire = 1'b1;
            end else if (tick) begin
               if (ypos_q >= STEP_W) ypos_d = ypos_q - STEP_W;
               else                  retire = 1'b1;
            end
         end
         S_COOL: begin
            if (tick) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (retire) begin
         if (COOL_W == 8'd0) begin
            state_d = S_IDLE;
         end else begin
            cnt_d   = COOL_W;
            state_d = S_COOL;
         end
      end
   end

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         xpos_q  <= '0;
         ypos_q  <= '0;
         cnt_q   <= '0;
         on_q    <= 1'b0;
         ready_q <= 1'b1;
         fire_q  <= 1'b0;
         vblnk_q <= 1'b0;
      end else begin
         state_q <= state_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         cnt_q   <= cnt_d;
         on_q    <= (state_d == S_FLY);
         ready_q <= (state_d == S_IDLE);
         fire_q  <= bus.fire;
         vblnk_q <= bus.vblnk_in;
      end
   end

   assign bus.xpos  = xpos_q;
   assign bus.ypos  = ypos_q;
   assign bus.on    = on_q;
   assign bus.ready = ready_q;

endmodule

// File: tb/tb_missile_ctl.sv
// Directed bench for missile_ctl with an expected-result queue.
// Define AUTOFIRE_EN for both bench and RTL to check the autofire build.
module tb_missile_ctl;

   typedef struct {
      string       tag;
      logic [10:0] x;
      logic [10:0] y;
      logic        on;
      logic        rdy;
   } exp_t;

   logic pclk;
   logic rst;
   int   checks;
   int   errors;
   exp_t sb[$];

   missile_ctl_if bus ();

   missile_ctl dut (
      .pclk (pclk),
      .rst  (rst),
      .bus  (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic tick();
      bus.vblnk_in = 1'b1;
      step();
      bus.vblnk_in = 1'b0;
      step();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic expect_out(input string t, input logic [10:0] x,
                             input logic [10:0] y, input logic o,
                             input logic r);
      exp_t e;
      e.tag = t;
      e.x   = x;
      e.y   = y;
      e.on  = o;
      e.rdy = r;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         errors++;
         $error("FAIL scoreboard empty: observed 0 entries, expected >=1");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks++;
         assert (bus.xpos === e.x) else begin
            errors++;
            $error("FAIL %s.xpos observed=%0d expected=%0d", e.tag, bus.xpos, e.x);
         end
         checks++;
         assert (bus.ypos === e.y) else begin
            errors++;
            $error("FAIL %s.ypos observed=%0d expected=%0d", e.tag, bus.ypos, e.y);
         end
         checks++;
         assert (bus.on === e.on) else begin
            errors++;
            $error("FAIL %s.on observed=%0b expected=%0b", e.tag, bus.on, e.on);
         end
         checks++;
         assert (bus.ready === e.rdy) else begin
            errors++;
            $error("FAIL %s.ready observed=%0b expected=%0b", e.tag, bus.ready, e.rdy);
         end
      end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.fire      = 1'b0;
      bus.ship_xpos = 11'd0;
      bus.ship_ypos = 11'd0;
      bus.vblnk_in  = 1'b0;
      bus.hit       = 1'b0;
      #3 rst = 1'b0;
      expect_out("reset_async", 11'd0, 11'd0, 1'b0, 1'b1);
      #1 check();
      step();
      rst = 1'b1;
      expect_out("reset_idle", 11'd0, 11'd0, 1'b0, 1'b1);
      step();
      step();
      check();

      // launch
      bus.ship_xpos = 11'd300;
      bus.ship_ypos = 11'd700;
      bus.fire      = 1'b1;
      expect_out("launch", 11'd300, 11'd680, 1'b1, 1'b0);
      step();
      check();
      bus.fire      = 1'b0;
      bus.ship_xpos = 11'd500;
      expect_out("climb3", 11'd300, 11'd656, 1'b1, 1'b0);
      ticks(3);
      check();

      // top-edge retirement
      expect_out("top85", 11'd300, 11'd0, 1'b1, 1'b0);
      ticks(82);
      check();
      expect_out("top86", 11'd300, 11'd0, 1'b0, 1'b0);
      tick();
      check();
      for (int i = 0; i < 9; i++) begin
         bus.fire = 1'b1;
         step();
         bus.fire = 1'b0;
         expect_out("cool_fire", 11'd300, 11'd0, 1'b0, 1'b0);
         tick();
         check();
      end
      expect_out("cool_done", 11'd300, 11'd0, 1'b0, 1'b1);
      tick();
      check();
      bus.fire = 1'b1;
      expect_out("relaunch", 11'd500, 11'd680, 1'b1, 1'b0);
      step();
      check();
      bus.fire = 1'b0;

      // hit together with a tick
      expect_out("at400", 11'd500, 11'd400, 1'b1, 1'b0);
      ticks(35);
      check();
      bus.hit      = 1'b1;
      bus.vblnk_in = 1'b1;
      expect_out("hit", 11'd500, 11'd400, 1'b0, 1'b0);
      step();
      check();
      bus.hit      = 1'b0;
      bus.vblnk_in = 1'b0;
      step();
      expect_out("hit_cool9", 11'd500, 11'd400, 1'b0, 1'b0);
      ticks(9);
      check();
      expect_out("hit_cool10", 11'd500, 11'd400, 1'b0, 1'b1);
      tick();
      check();

      // launch guard and exact-height boundary
      bus.ship_ypos = 11'd10;
      bus.fire      = 1'b1;
      expect_out("guard", 11'd500, 11'd400, 1'b0, 1'b1);
      step();
      check();
      bus.fire = 1'b0;
      step();
      bus.ship_ypos = 11'd20;
      bus.ship_xpos = 11'd77;
      bus.fire      = 1'b1;
      expect_out("edge_launch", 11'd77, 11'd0, 1'b1, 1'b0);
      step();
      check();
      bus.fire = 1'b0;
      expect_out("edge_retire", 11'd77, 11'd0, 1'b0, 1'b0);
      tick();
      check();
      expect_out("edge_cool", 11'd77, 11'd0, 1'b0, 1'b1);
      ticks(10);
      check();

      // reset while flying
      bus.ship_xpos = 11'd300;
      bus.ship_ypos = 11'd700;
      bus.fire      = 1'b1;
      step();
      bus.fire = 1'b0;
      expect_out("fly400", 11'd300, 11'd400, 1'b1, 1'b0);
      ticks(35);
      check();
      rst = 1'b0;
      expect_out("reset_flight", 11'd0, 11'd0, 1'b0, 1'b1);
      #2 check();
      step();
      rst = 1'b1;
      step();

      // held fire through a full cycle
      bus.fire = 1'b1;
      expect_out("held_launch", 11'd300, 11'd680, 1'b1, 1'b0);
      step();
      check();
      bus.hit = 1'b1;
      step();
      bus.hit = 1'b0;
`ifdef AUTOFIRE_EN
      expect_out("held_after", 11'd300, 11'd680, 1'b1, 1'b0);
`else
      expect_out("held_after", 11'd300, 11'd680, 1'b0, 1'b1);
`endif
      ticks(10);
      check();
      bus.fire = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
